// File: rtl/stream_upsizer.sv
// Packs RATIO narrow valid/ready beats into one registered wide output word.
// Optional UPSIZER_LAST_EN adds s_last/m_last/m_keep for early word termination.
module stream_upsizer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RATIO = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH-1:0]         s_data,
`ifdef UPSIZER_LAST_EN
    input  logic                     s_last,
`endif
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH*RATIO-1:0]   m_data
`ifdef UPSIZER_LAST_EN
    ,
    output logic                     m_last,
    output logic [RATIO-1:0]         m_keep
`endif
);

    localparam int unsigned IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned ACC_W  = WIDTH * (RATIO - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [ACC_W-1:0]       acc;
    logic [IDX_W-1:0]       idx;
    logic                   accept_c;
    logic                   final_c;
    logic [WIDTH*RATIO-1:0] word_c;
`ifdef UPSIZER_LAST_EN
    logic [RATIO-1:0]       keep_c;
`endif

    // Handshake and word-completion decode
    always_comb begin
`ifdef UPSIZER_LAST_EN
        s_ready = !m_valid || m_ready;
        final_c = (idx == LAST_IDX) || s_last;
`else
        s_ready = (idx != LAST_IDX) || !m_valid || m_ready;
        final_c = (idx == LAST_IDX);
`endif
        accept_c = s_valid && s_ready;
    end

    // Lanes at and above idx in acc are always zero, so the completing beat
    // only needs to be dropped into lane idx.
    always_comb begin
        word_c = {{WIDTH{1'b0}}, acc};
`ifdef UPSIZER_LAST_EN
        keep_c = '0;
`endif
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (IDX_W'(k) == idx) begin
                word_c[k*WIDTH +: WIDTH] = s_data;
            end
`ifdef UPSIZER_LAST_EN
            keep_c[k] = (IDX_W'(k) <= idx);
`endif
        end
    end

    // Accumulator, lane counter and output register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc     <= '0;
            idx     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
`ifdef UPSIZER_LAST_EN
            m_last  <= 1'b0;
            m_keep  <= '0;
`endif
        end else begin
            if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (accept_c) begin
                if (final_c) begin
                    acc     <= '0;
                    idx     <= '0;
                    m_valid <= 1'b1;
                    m_data  <= word_c;
`ifdef UPSIZER_LAST_EN
                    m_last  <= s_last;
                    m_keep  <= keep_c;
`endif
                end else begin
                    for (int unsigned k = 0; k < RATIO - 1; k++) begin
                        if (IDX_W'(k) == idx) begin
                            acc[k*WIDTH +: WIDTH] <= s_data;
                        end
                    end
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// Self-checking bench for stream_upsizer: directed scenarios plus randomized
// traffic against a queue-based packing model. Define UPSIZER_LAST_EN for last/keep.
module tb_stream_upsizer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned RATIO = 4;
    localparam int unsigned WW    = WIDTH * RATIO;
`ifdef UPSIZER_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    typedef struct packed {
        logic [WW-1:0]    data;
        logic [RATIO-1:0] keep;
        logic             last;
    } word_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_last = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WW-1:0]    m_data;
`ifdef UPSIZER_LAST_EN
    logic             m_last;
    logic [RATIO-1:0] m_keep;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: beats of the word being built, and words awaiting drain
    logic [WIDTH-1:0] part[$];
    word_t            outq[$];

    stream_upsizer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
`ifdef UPSIZER_LAST_EN
        .s_last  (s_last),
        .m_last  (m_last),
        .m_keep  (m_keep),
`endif
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    always #5 clk = ~clk;

    function automatic logic model_ready();
        if (LAST_EN) return (outq.size() == 0) || m_ready;
        return (part.size() != int'(RATIO) - 1) || (outq.size() == 0) || m_ready;
    endfunction

    // Drive one cycle's inputs away from the active edge and let them settle
    task automatic put(input logic v, input logic [WIDTH-1:0] d, input logic rdy, input logic last);
        @(negedge clk);
        rstn = 1'b1; s_valid = v; s_data = d; m_ready = rdy; s_last = last;
        #1;
    endtask

    // Advance one clock edge and update the model from the driven inputs
    task automatic tick();
        logic  acc, drn;
        word_t w;
        acc = s_valid && model_ready();
        drn = (outq.size() != 0) && m_ready;
        @(posedge clk);
        if (!rstn) begin
            part.delete();
            outq.delete();
            return;
        end
        if (drn) void'(outq.pop_front());
        if (acc) begin
            part.push_back(s_data);
            if (part.size() == int'(RATIO) || (LAST_EN && s_last)) begin
                w = '0;
                foreach (part[i]) begin
                    w.data[i*WIDTH +: WIDTH] = part[i];
                    w.keep[i] = 1'b1;
                end
                w.last = LAST_EN && s_last;
                outq.push_back(w);
                part.delete();
            end
        end
    endtask

    task automatic do_reset();
        put(1'b0, '0, 1'b1, 1'b0);
        rstn = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        put(1'b0, '0, 1'b1, 1'b0);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data got %h want 0", m_data); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
`ifdef UPSIZER_LAST_EN
        checks++; if (m_keep !== '0 || m_last !== 1'b0) begin errors++; $display("FAIL reset_keep_last got %b/%b want 0000/0", m_keep, m_last); end
`endif
        tick();
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] b[4];
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            put(1'b1, b[i], 1'b1, 1'b0);
            checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL basic_beat%0d rdy/vld got %b/%b want 1/0", i, s_ready, m_valid); end
            tick();
        end
        put(1'b0, '0, 1'b1, 1'b0);
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h44332211) begin errors++; $display("FAIL basic_word got %b/%h want 1/44332211", m_valid, m_data); end
        tick();
        put(1'b0, '0, 1'b1, 1'b0);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %b want 0", m_valid); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] b[4];
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            put(1'b1, b[i], 1'b0, 1'b0);
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_fill%0d s_ready got %b want 1", i, s_ready); end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            put(1'b0, '0, 1'b0, 1'b0);
            checks++; if (m_valid !== 1'b1 || m_data !== 32'h44332211) begin errors++; $display("FAIL bp_hold%0d got %b/%h want 1/44332211", i, m_valid, m_data); end
            tick();
        end
`ifndef UPSIZER_LAST_EN
        b = '{8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 3; i++) begin
            put(1'b1, b[i], 1'b0, 1'b0);
            checks++; if (s_ready !== 1'b1 || m_data !== 32'h44332211) begin errors++; $display("FAIL bp_partial%0d got %b/%h want 1/44332211", i, s_ready, m_data); end
            tick();
        end
        put(1'b1, 8'h88, 1'b0, 1'b0);
        checks++; if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'h44332211) begin errors++; $display("FAIL bp_stall got %b/%b/%h want 0/1/44332211", s_ready, m_valid, m_data); end
        tick();
        put(1'b1, 8'h88, 1'b1, 1'b0);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", s_ready); end
        tick();
`else
        put(1'b1, 8'h55, 1'b0, 1'b0);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_any got %b want 0", s_ready); end
        tick();
        b = '{8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 4; i++) begin
            put(1'b1, b[i], 1'b1, 1'b0);
            tick();
        end
`endif
        put(1'b0, '0, 1'b1, 1'b0);
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h88776655) begin errors++; $display("FAIL bp_next got %b/%h want 1/88776655", m_valid, m_data); end
        tick();
        put(1'b0, '0, 1'b1, 1'b0);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", m_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            put(1'b1, WIDTH'(i + 1), 1'b1, 1'b0);
            checks++; if (s_ready !== 1'b1 || m_valid !== (i == 4)) begin errors++; $display("FAIL b2b_beat%0d rdy/vld got %b/%b want 1/%b", i, s_ready, m_valid, (i == 4)); end
            if (i == 4) begin
                checks++; if (m_data !== 32'h04030201) begin errors++; $display("FAIL b2b_word0 got %h want 04030201", m_data); end
            end
            tick();
        end
        put(1'b0, '0, 1'b1, 1'b0);
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h08070605) begin errors++; $display("FAIL b2b_word1 got %b/%h want 1/08070605", m_valid, m_data); end
        tick();
    endtask

    task automatic test_reset_mid_word();
        logic [WIDTH-1:0] b[4];
        do_reset();
        put(1'b1, 8'hA1, 1'b1, 1'b0); tick();
        put(1'b1, 8'hA2, 1'b1, 1'b0); tick();
        put(1'b0, '0, 1'b1, 1'b0); rstn = 1'b0; tick();
        b = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        for (int i = 0; i < 4; i++) begin
            put(1'b1, b[i], 1'b1, 1'b0);
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmw_beat%0d m_valid got %b want 0", i, m_valid); end
            tick();
        end
        put(1'b0, '0, 1'b1, 1'b0);
        checks++; if (m_valid !== 1'b1 || m_data !== 32'hB4B3B2B1) begin errors++; $display("FAIL rmw_word got %b/%h want 1/b4b3b2b1", m_valid, m_data); end
        tick();
        put(1'b0, '0, 1'b1, 1'b0);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmw_single got %b want 0", m_valid); end
        tick();
        // A pending undrained word must be dropped by reset
        for (int i = 0; i < 4; i++) begin
            put(1'b1, WIDTH'(8'hC1 + i), 1'b0, 1'b0); tick();
        end
        put(1'b0, '0, 1'b0, 1'b0); rstn = 1'b0;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rmw_pending got %b want 1", m_valid); end
        tick();
        put(1'b0, '0, 1'b0, 1'b0);
        checks++; if (m_valid !== 1'b0 || m_data !== '0) begin errors++; $display("FAIL rmw_dropped got %b/%h want 0/0", m_valid, m_data); end
        tick();
    endtask

`ifdef UPSIZER_LAST_EN
    task automatic test_last();
        do_reset();
        put(1'b1, 8'hAA, 1'b1, 1'b0); tick();
        put(1'b1, 8'hBB, 1'b1, 1'b1); tick();
        put(1'b0, '0, 1'b1, 1'b0);
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h0000BBAA || m_keep !== 4'b0011 || m_last !== 1'b1) begin
            errors++; $display("FAIL last_short got %b/%h/%b/%b want 1/0000bbaa/0011/1", m_valid, m_data, m_keep, m_last); end
        tick();
        for (int i = 0; i < 4; i++) begin
            put(1'b1, WIDTH'(8'hCC + i), 1'b1, 1'b0); tick();
        end
        put(1'b0, '0, 1'b1, 1'b0);
        checks++; if (m_data !== 32'hCFCECDCC || m_keep !== 4'b1111 || m_last !== 1'b0) begin
            errors++; $display("FAIL last_full_nolast got %h/%b/%b want cfcecdcc/1111/0", m_data, m_keep, m_last); end
        tick();
        for (int i = 0; i < 4; i++) begin
            put(1'b1, WIDTH'(i + 1), 1'b1, (i == 3)); tick();
        end
        put(1'b0, '0, 1'b1, 1'b0);
        checks++; if (m_data !== 32'h04030201 || m_keep !== 4'b1111 || m_last !== 1'b1) begin
            errors++; $display("FAIL last_full_last got %h/%b/%b want 04030201/1111/1", m_data, m_keep, m_last); end
        tick();
    endtask
`endif

    task automatic test_random();
        word_t exp;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            put(($urandom_range(0, 3) != 0), WIDTH'($urandom), ($urandom_range(0, 9) < 6),
                LAST_EN && ($urandom_range(0, 4) == 0));
            checks++; if (s_ready !== model_ready()) begin errors++; $display("FAIL rnd_s_ready@%0d got %b want %b", n, s_ready, model_ready()); end
            checks++; if (m_valid !== (outq.size() != 0)) begin errors++; $display("FAIL rnd_m_valid@%0d got %b want %b", n, m_valid, (outq.size() != 0)); end
            if (outq.size() != 0) begin
                exp = outq[0];
                checks++; if (m_data !== exp.data) begin errors++; $display("FAIL rnd_m_data@%0d got %h want %h", n, m_data, exp.data); end
`ifdef UPSIZER_LAST_EN
                checks++; if (m_keep !== exp.keep || m_last !== exp.last) begin errors++; $display("FAIL rnd_keep_last@%0d got %b/%b want %b/%b", n, m_keep, m_last, exp.keep, exp.last); end
`endif
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
`ifdef UPSIZER_LAST_EN
        test_last();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
